// File: rtl/vending_txn_sequencer_if.sv
// Bus between the purchase sequencer and its host/DUT side.
// Groups the script-config port, the playback control and the phase outputs
// driven towards the vending controller.
//   master : the sequencer (drives phase strobes, payload, status)
//   slave  : host / bench / vending controller side
// Optional macro VEND_SEQ_RANDOM_EN adds the rnd_mode input.
interface vending_txn_sequencer_if #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned N_COIN  = 3,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PROD_W  = 8,
    parameter int unsigned MONEY_W = 8
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned COINS_W = N_COIN * CNT_W;

    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_addr;
    logic [PROD_W-1:0]    cfg_prod;
    logic [COINS_W-1:0]   cfg_coins;
    logic [IDX_W:0]       cfg_len;
    logic                 start;
    logic                 dut_ready;
`ifdef VEND_SEQ_RANDOM_EN
    logic                 rnd_mode;
`endif
    logic                 escolher;
    logic                 inserir_dinheiro;
    logic                 dar_troco;
    logic [PROD_W-1:0]    produto_escolhido;
    logic [MONEY_W-1:0]   dinheiro_inserido;
    logic [COINS_W-1:0]   moedas_inseridas;
    logic                 busy;
    logic                 done;
    logic                 overflow;

    modport master (
`ifdef VEND_SEQ_RANDOM_EN
        input  rnd_mode,
`endif
        input  cfg_we, cfg_addr, cfg_prod, cfg_coins, cfg_len, start, dut_ready,
        output escolher, inserir_dinheiro, dar_troco, produto_escolhido,
               dinheiro_inserido, moedas_inseridas, busy, done, overflow
    );

    modport slave (
`ifdef VEND_SEQ_RANDOM_EN
        output rnd_mode,
`endif
        output cfg_we, cfg_addr, cfg_prod, cfg_coins, cfg_len, start, dut_ready,
        input  escolher, inserir_dinheiro, dar_troco, produto_escolhido,
               dinheiro_inserido, moedas_inseridas, busy, done, overflow
    );
endinterface

// File: rtl/vending_txn_sequencer.sv
// Scripted purchase-sequence generator for the vending-machine bench/demo top.
// Plays back up to DEPTH purchases, each as CLEAR -> ESCOLHER -> INSERIR -> TROCO,
// advancing phases on a dut_ready handshake after a minimum hold time.
// The money total is derived from per-denomination coin counts.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : vending_txn_sequencer_if.master (config, start, dut_ready in;
//           phase strobes, product/money/coin payload, busy/done/overflow out)
// Optional macro VEND_SEQ_RANDOM_EN: rnd_mode=1 at start plays LFSR-generated
// purchases instead of the script RAM.
module vending_txn_sequencer #(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          N_COIN    = 3,
    parameter int unsigned          CNT_W     = 8,
    parameter int unsigned          PROD_W    = 8,
    parameter int unsigned          MONEY_W   = 8,
    parameter logic [N_COIN*8-1:0]  COIN_VAL  = {8'd100, 8'd50, 8'd25},
    parameter int unsigned          MIN_PHASE = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    vending_txn_sequencer_if.master  bus
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam int unsigned CMP_W   = LEN_W + 1;
    localparam int unsigned COINS_W = N_COIN * CNT_W;
    localparam int unsigned SUM_W   = MONEY_W + CNT_W + $clog2(N_COIN) + 1;
    localparam int unsigned HOLD_W  = $clog2(MIN_PHASE) + 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_PHASE - 1);
    localparam logic [SUM_W-1:0]  MONEY_MAX = SUM_W'({MONEY_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ESCOLHER, S_INSERIR, S_TROCO, S_FINISH
    } state_t;

    state_t              state, state_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [LEN_W-1:0]    idx, idx_n, len, len_n;
    logic [PROD_W-1:0]   prod_q, prod_n, src_prod_c;
    logic [COINS_W-1:0]  coins_q, coins_n, src_coins_c;
    logic [MONEY_W-1:0]  money_q, money_n;
    logic                ovf_n;
    logic                phase_exit_c;
    logic [SUM_W-1:0]    sum_c;

    logic [PROD_W-1:0]   ram_prod  [DEPTH];
    logic [COINS_W-1:0]  ram_coins [DEPTH];

    // Script RAM: not reset, writable at any time (active purchase is latched)
    always_ff @(posedge clock) begin
        if (bus.cfg_we) begin
            ram_prod[bus.cfg_addr]  <= bus.cfg_prod;
            ram_coins[bus.cfg_addr] <= bus.cfg_coins;
        end
    end

`ifdef VEND_SEQ_RANDOM_EN
    logic        rnd_q, rnd_n;
    logic [15:0] lfsr_q, lfsr_n;

    // Purchase source: LFSR fields in random mode, script RAM otherwise
    always_comb begin
        src_prod_c  = ram_prod[idx[IDX_W-1:0]];
        src_coins_c = ram_coins[idx[IDX_W-1:0]];
        if (rnd_q) begin
            src_prod_c  = PROD_W'(lfsr_q[IDX_W-1:0]);
            src_coins_c = '0;
            for (int unsigned i = 0; i < N_COIN; i++)
                src_coins_c[i*CNT_W +: CNT_W] = CNT_W'(lfsr_q[2*i +: 2]);
        end
    end
`else
    assign src_prod_c  = ram_prod[idx[IDX_W-1:0]];
    assign src_coins_c = ram_coins[idx[IDX_W-1:0]];
`endif

    // Money total at a width that cannot wrap before the saturation check
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < N_COIN; i++)
            sum_c = sum_c + SUM_W'(src_coins_c[i*CNT_W +: CNT_W]) * SUM_W'(COIN_VAL[i*8 +: 8]);
    end

    // Next-state and next-payload logic
    always_comb begin
        state_n      = state;
        hold_n       = hold_cnt;
        idx_n        = idx;
        len_n        = len;
        prod_n       = prod_q;
        coins_n      = coins_q;
        money_n      = money_q;
        ovf_n        = bus.overflow;
`ifdef VEND_SEQ_RANDOM_EN
        rnd_n        = rnd_q;
        lfsr_n       = lfsr_q;
`endif
        phase_exit_c = (hold_cnt >= HOLD_MAX) && bus.dut_ready;

        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    len_n = bus.cfg_len;
                    idx_n = '0;
                    ovf_n = 1'b0;
`ifdef VEND_SEQ_RANDOM_EN
                    rnd_n = bus.rnd_mode;
`endif
                    state_n = (bus.cfg_len == '0) ? S_FINISH : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (phase_exit_c) begin
                    state_n = S_ESCOLHER;
                    prod_n  = src_prod_c;
                    coins_n = src_coins_c;
                    if (sum_c > MONEY_MAX) begin
                        money_n = '1;
                        ovf_n   = 1'b1;
                    end else begin
                        money_n = MONEY_W'(sum_c);
                    end
`ifdef VEND_SEQ_RANDOM_EN
                    // Galois LFSR, taps 16,14,13,11
                    if (rnd_q)
                        lfsr_n = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
`endif
                end
            end
            S_ESCOLHER: if (phase_exit_c) state_n = S_INSERIR;
            S_INSERIR:  if (phase_exit_c) state_n = S_TROCO;
            S_TROCO: begin
                if (phase_exit_c) begin
                    if (CMP_W'(idx) + CMP_W'(1) < CMP_W'(len)) begin
                        idx_n   = idx + LEN_W'(1);
                        state_n = S_CLEAR;
                    end else begin
                        state_n = S_FINISH;
                    end
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // Hold counter saturates so a long dut_ready stall cannot wrap it
        if (state inside {S_CLEAR, S_ESCOLHER, S_INSERIR, S_TROCO}) begin
            if (phase_exit_c)
                hold_n = '0;
            else if (hold_cnt < HOLD_MAX)
                hold_n = hold_cnt + HOLD_W'(1);
        end
    end

    // State and registered outputs, aligned with the state they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                 <= S_IDLE;
            hold_cnt              <= '0;
            idx                   <= '0;
            len                   <= '0;
            prod_q                <= '0;
            coins_q               <= '0;
            money_q               <= '0;
`ifdef VEND_SEQ_RANDOM_EN
            rnd_q                 <= 1'b0;
            lfsr_q                <= 16'hACE1;
`endif
            bus.escolher          <= 1'b0;
            bus.inserir_dinheiro  <= 1'b0;
            bus.dar_troco         <= 1'b0;
            bus.produto_escolhido <= '0;
            bus.dinheiro_inserido <= '0;
            bus.moedas_inseridas  <= '0;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
            bus.overflow          <= 1'b0;
        end else begin
            state                 <= state_n;
            hold_cnt              <= hold_n;
            idx                   <= idx_n;
            len                   <= len_n;
            prod_q                <= prod_n;
            coins_q               <= coins_n;
            money_q               <= money_n;
`ifdef VEND_SEQ_RANDOM_EN
            rnd_q                 <= rnd_n;
            lfsr_q                <= lfsr_n;
`endif
            bus.escolher          <= (state_n == S_ESCOLHER);
            bus.inserir_dinheiro  <= (state_n == S_INSERIR);
            bus.dar_troco         <= (state_n == S_TROCO);
            bus.produto_escolhido <= (state_n inside {S_ESCOLHER, S_INSERIR, S_TROCO}) ? prod_n : '0;
            bus.dinheiro_inserido <= (state_n inside {S_INSERIR, S_TROCO}) ? money_n : '0;
            bus.moedas_inseridas  <= (state_n inside {S_INSERIR, S_TROCO}) ? coins_n : '0;
            bus.busy              <= (state_n != S_IDLE);
            bus.done              <= (state_n == S_FINISH);
            bus.overflow          <= ovf_n;
        end
    end
endmodule
